// File: rtl/sev_seg_scan_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Digit values, anode polarity and the two scan phases live here.
package sev_seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam logic AN_OFF  = 1'b1;

    typedef enum logic [0:0] {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_phase_t;

endpackage

// File: rtl/sev_seg_scan_if.sv
// Frame-load handshake between a producer and the seven-segment scanner.
interface sev_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_digits;

    modport master (output load_valid, output load_digits, input load_ready);
    modport slave  (input load_valid, input load_digits, output load_ready);
endinterface

// File: rtl/sev_seg_lz_mask.sv
// Per-digit suppress mask: invalid BCD values, plus leading zeros when blanking
// is enabled. Digit 0 is only ever suppressed for being invalid.
module sev_seg_lz_mask
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  bcd_t [NUM_DIGITS-1:0] digits,
    input  logic                  blank_lz,
    output logic [NUM_DIGITS-1:0] suppress
);

    // zero_from[i] is set when digits NUM_DIGITS-1 down to i are all zero
    logic [NUM_DIGITS:1] zero_from;

    assign zero_from[NUM_DIGITS] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_lsd
            assign suppress[gi] = (digits[gi] > BCD_MAX);
        end else begin : g_upper
            assign zero_from[gi] = zero_from[gi+1] && (digits[gi] == 4'd0);
            assign suppress[gi]  = (digits[gi] > BCD_MAX) || (blank_lz && zero_from[gi]);
        end
    end

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed seven-segment scanner: per-digit DEAD/ON slots, a pending
// frame buffer committed only at frame end, and registered data/anode outputs.
module sev_seg_scan
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DEAD_CYCLES = 4,
    parameter int ON_CYCLES   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    sev_seg_scan_if.slave         load,
    input  logic                  blank_lz,
    output bcd_t                  data,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int MAX_CYC = (DEAD_CYCLES > ON_CYCLES) ? DEAD_CYCLES : ON_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    scan_phase_t           phase_reg, phase_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    bcd_t                  data_reg, data_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic                  supp_reg, supp_next;
    logic                  ready_reg, ready_next;
    bcd_t [NUM_DIGITS-1:0] disp_reg, disp_next;
    bcd_t [NUM_DIGITS-1:0] pend_reg, pend_next;
    logic                  full_reg, full_next;
    logic [NUM_DIGITS-1:0] suppress;

    // Right after reset ready is low with nothing pending; that one cycle only
    // arms the handshake and starts the digit 0 slot.
    logic init, end_dead, end_on, last_digit, commit, xfer, slot_start;

    assign init       = !ready_reg && !full_reg;
    assign end_dead   = (phase_reg == DEAD) && (cnt_reg == CNT_W'(DEAD_CYCLES - 1));
    assign end_on     = (phase_reg == ON) && (cnt_reg == CNT_W'(ON_CYCLES - 1));
    assign last_digit = (idx_reg == IDX_W'(NUM_DIGITS - 1));
    assign commit     = !init && end_on && last_digit && full_reg;
    assign xfer       = load.load_valid && ready_reg;
    assign slot_start = init || end_on;

    always_comb begin
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        if (init) begin
            phase_next = DEAD;
            cnt_next   = '0;
            idx_next   = '0;
        end else if (end_dead) begin
            phase_next = ON;
            cnt_next   = '0;
        end else if (end_on) begin
            phase_next = DEAD;
            cnt_next   = '0;
            idx_next   = last_digit ? '0 : idx_reg + IDX_W'(1);
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // The mask sees the display as it will be after this edge, so a commit is
    // visible in the very next slot.
    assign disp_next = commit ? pend_reg : disp_reg;

    sev_seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
        .digits   (disp_next),
        .blank_lz (blank_lz),
        .suppress (suppress)
    );

    always_comb begin
        supp_next  = supp_reg;
        data_next  = data_reg;
        ready_next = ready_reg;
        pend_next  = pend_reg;
        full_next  = full_reg;
        an_next    = {NUM_DIGITS{AN_OFF}};
        if (slot_start) begin
            supp_next = suppress[idx_next];
            data_next = supp_next ? 4'd0 : disp_next[idx_next];
        end
        if (phase_next == ON && !supp_next)
            an_next[idx_next] = 1'b0;
        if (init || commit) begin
            ready_next = 1'b1;
            full_next  = 1'b0;
        end
        if (xfer) begin
            pend_next  = load.load_digits;
            full_next  = 1'b1;
            ready_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= DEAD;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            an_reg    <= {NUM_DIGITS{AN_OFF}};
            supp_reg  <= 1'b0;
            ready_reg <= 1'b0;
            disp_reg  <= '0;
            pend_reg  <= '0;
            full_reg  <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            an_reg    <= an_next;
            supp_reg  <= supp_next;
            ready_reg <= ready_next;
            disp_reg  <= disp_next;
            pend_reg  <= pend_next;
            full_reg  <= full_next;
        end
    end

    assign data            = data_reg;
    assign an              = an_reg;
    assign load.load_ready = ready_reg;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Randomized bench for sev_seg_scan against a slot/frame-time reference model.
module tb_sev_seg_scan;

    localparam int ND    = 4;
    localparam int DC    = 2;
    localparam int OC    = 5;
    localparam int SLOT  = DC + OC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        blank_lz;
    logic [3:0]  data;
    logic [3:0]  an;

    sev_seg_scan_if #(.NUM_DIGITS(ND)) load_bus ();

    sev_seg_scan #(
        .NUM_DIGITS  (ND),
        .DEAD_CYCLES (DC),
        .ON_CYCLES   (OC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load_bus),
        .blank_lz (blank_lz),
        .data     (data),
        .an       (an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: k is the cycle position inside the frame, -1 while the
    // first cycle after reset is still pending.
    int          k;
    logic        m_ready, m_full;
    logic [15:0] m_pend;
    logic [3:0]  m_disp [ND];
    logic [3:0]  e_data;
    logic        e_supp;

    task automatic slot_load();
        int   idx;
        logic lead;
        idx  = k / SLOT;
        lead = blank_lz && (idx != 0);
        for (int j = idx; j < ND; j++)
            if (m_disp[j] != 4'd0) lead = 1'b0;
        e_supp = (m_disp[idx] > 4'd9) || lead;
        e_data = e_supp ? 4'd0 : m_disp[idx];
    endtask

    task automatic model_edge();
        logic cap, com;
        if (rst) begin
            k       = -1;
            m_ready = 1'b0;
            m_full  = 1'b0;
            m_pend  = '0;
            for (int i = 0; i < ND; i++) m_disp[i] = 4'd0;
            e_data  = 4'd0;
            e_supp  = 1'b0;
        end else if (k < 0) begin
            m_ready = 1'b1;
            k       = 0;
            slot_load();
        end else begin
            cap = load_bus.load_valid && m_ready;
            com = (k == FRAME - 1) && m_full;
            k   = (k + 1) % FRAME;
            if (com) begin
                for (int i = 0; i < ND; i++) m_disp[i] = m_pend[4*i +: 4];
                m_full  = 1'b0;
                m_ready = 1'b1;
            end
            if (k % SLOT == 0) slot_load();
            if (cap) begin
                m_pend  = load_bus.load_digits;
                m_full  = 1'b1;
                m_ready = 1'b0;
                $display("load captured %h blank_lz=%0b at %0t", m_pend, blank_lz, $time);
            end
        end
    endtask

    function automatic logic [3:0] exp_an();
        logic [3:0] v;
        v = 4'hF;
        if (k >= 0 && (k % SLOT) >= DC && !e_supp) v[k / SLOT] = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] pick_digits();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h1234;
            1: v = 16'h0070;
            2: v = 16'h0000;
            3: v = 16'h12A4;
            4: v = 16'h5678;
            default: begin
                for (int i = 0; i < 4; i++)
                    v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
        endcase
        return v;
    endfunction

    initial begin
        rst                  = 1'b1;
        blank_lz             = 1'b0;
        load_bus.load_valid  = 1'b0;
        load_bus.load_digits = 16'h1234;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("an", an, exp_an());
            check("data", data, e_data);
            check("load_ready", load_bus.load_ready, m_ready);
            // Next inputs, applied well before the following edge.
            if (c < 3) begin
                rst = 1'b1;
            end else if (c < 120) begin
                rst                  = 1'b0;
                load_bus.load_valid  = 1'b1;
                load_bus.load_digits = (c < 60) ? 16'h1234 : 16'h0070;
                blank_lz             = (c >= 60);
            end else begin
                rst = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 59) == 0) blank_lz = ~blank_lz;
                if ($urandom_range(0, 3) == 0) load_bus.load_digits = pick_digits();
                if ($urandom_range(0, 9) == 0) load_bus.load_valid = ~load_bus.load_valid;
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sev_seg_scan.md
Name: sev_seg_scan

Overview:
- Time-multiplexed scanner for a NUM_DIGITS common-anode seven-segment display.
- Holds a frame of BCD digits loaded over a valid/ready handshake.
- Drives one digit at a time onto the 4-bit BCD input of the downstream sev_seg decoder, which is valid for values 0-9 only, and drives the matching active-low anode.
- Inserts dead time between digits to prevent ghosting, optionally blanks leading zeros, and applies new values only at frame boundaries so the display never tears.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; digit 0 is least significant.
- DEAD_CYCLES, 4: cycles per digit slot with all anodes off; must be ≥1.
- ON_CYCLES, 1000: cycles per digit slot with the anode on; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- load_valid  in  1  load_digits is offered
- load_ready  out  1  block can accept a new frame
- load_digits  in  4*NUM_DIGITS  BCD digits; digit i is bits [4i+3:4i]
- blank_lz  in  1  enables leading-zero blanking; sampled each slot start
- data  out  4  BCD value to sev_seg
- an  out  NUM_DIGITS  anode enables, active-low

Behaviour:
- Reset (rst high at a clock edge):
  - Takes effect on that edge and wins over all other events.
  - an = all ones; data = 0; load_ready = 0; display register = all zero; pending register empty.
  - digit index = 0; phase = DEAD; phase counter = 0.
- First cycle after reset deasserts: load_ready = 1, DEAD phase of digit 0 begins.
- All outputs are registered.
- Per-slot FSM:
  - DEAD: lasts DEAD_CYCLES cycles; an = all ones. On the first DEAD cycle, data is loaded with the display value of the current index, or 0 if the digit is suppressed. data stays stable for the whole slot.
  - ON: lasts ON_CYCLES cycles. an[idx] = 0 unless the digit is suppressed; all other anode bits are 1.
  - End of ON: index increments, wrapping NUM_DIGITS-1 → 0; next state is DEAD.
  - Frame = NUM_DIGITS*(DEAD_CYCLES+ON_CYCLES) cycles.
- Suppression of digit i (anode stays high for the whole slot, data = 0):
  - The digit value is greater than 9 (sev_seg is undefined there), or
  - blank_lz = 1, i ≠ 0, and digits NUM_DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked as a leading zero, but is still suppressed if invalid.
- Handshake:
  - A transfer occurs when load_valid && load_ready at a clock edge.
  - load_digits is captured into the pending register; load_ready = 0 from the next cycle.
  - load_valid may stay high while load_ready = 0; nothing is captured.
- Commit:
  - Occurs on the cycle the ON phase of digit NUM_DIGITS-1 ends.
  - If pending is full: pending is copied into the display register, pending is cleared, and load_ready = 1 from the next cycle.
  - The new values first appear in the digit 0 DEAD phase that follows.
  - A transfer and a commit cannot coincide, because load_ready = 0 whenever pending is full.
- Counter width: clog2 of max(DEAD_CYCLES, ON_CYCLES). The counter resets to 0 at every phase change.
- Reset mid-operation discards the pending and display contents.

Decomposition:
- Shared package sev_seg_pkg:
  - BCD digit typedef (logic [3:0]).
  - Constants: BCD_MAX = 9, AN_OFF = '1.
  - Scan-phase enum {DEAD, ON}.
- One sub-module, sev_seg_lz_mask: combinational. Maps the display register plus blank_lz to a NUM_DIGITS-bit suppress mask covering both invalid-digit and leading-zero suppression.
- The top level holds the FSM, counters, handshake and registers.
- Downstream sev_seg is instantiated by the parent, not inside this block.

Test Plan:
All tests use NUM_DIGITS=4, DEAD_CYCLES=2, ON_CYCLES=5 (frame = 28 cycles).
1. Reset, load 16'h1234 with blank_lz=0 → after the first commit, each slot holds an=1111 for 2 cycles and then for 5 cycles shows, in order: an=1110 with data=4; an=1101 with data=3; an=1011 with data=2; an=0111 with data=1. The sequence repeats every 28 cycles.
2. Load 16'h0070 with blank_lz=1 → digits 3 and 2 keep an=1111 for the whole slot with data=0; digit 1 shows data=7; digit 0 shows data=0. Load 16'h0000 → only digit 0 lights, with data=0.
3. Load 16'h12A4 → the digit 1 slot keeps an=1111 with data=0; digits 0, 2 and 3 show 4, 2 and 1.
4. Assert load_valid with 16'h5678 during the digit 1 ON phase → load_ready drops the next cycle. The display continues showing the old frame until digit 3 ON ends. A second value held on load_valid is accepted only after load_ready returns to 1 the cycle after commit.
5. Assert rst for 1 cycle during digit 2 ON → next cycle an=1111, data=0, load_ready=0. The cycle after that, load_ready=1 and the digit 0 DEAD phase starts, with the display cleared.
6. Hold load_valid high continuously with changing data → exactly one capture per frame. Each capture equals the value present on the cycle load_ready was 1.
